// File: rtl/hw_barrier_multi.sv
// Multi-barrier hardware synchroniser: per-barrier team size, wake-up mask and
// per-core arrival bitmap, with registered completion and wake-up pulses.
module hw_barrier_multi #(
    parameter  int NUM_CORES    = 8,
    parameter  int NUM_BARRIERS = 4,
    localparam int BID_W        = $clog2(NUM_BARRIERS),
    localparam int CNT_W        = $clog2(NUM_CORES) + 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       cfg_valid_i,
    input  logic [BID_W-1:0]           cfg_id_i,
    input  logic [CNT_W-1:0]           cfg_num_threads_i,
    input  logic [NUM_CORES-1:0]       cfg_mask_i,
    input  logic [NUM_BARRIERS-1:0]    clear_i,
    input  logic [NUM_CORES-1:0]       arrive_valid_i,
    input  logic [NUM_CORES*BID_W-1:0] arrive_id_i,
    output logic [NUM_CORES-1:0]       barrier_event_o,
    output logic [NUM_BARRIERS-1:0]    barrier_done_o,
    input  logic [BID_W-1:0]           status_id_i,
    output logic [CNT_W-1:0]           status_count_o,
    input  logic                       err_clr_i,
    output logic                       err_dup_o,
    output logic                       err_unconf_o
);

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_CORES-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    // Per-barrier architectural state.
    logic [CNT_W-1:0]        num_q  [NUM_BARRIERS];
    logic [CNT_W-1:0]        num_d  [NUM_BARRIERS];
    logic [NUM_CORES-1:0]    mask_q [NUM_BARRIERS];
    logic [NUM_CORES-1:0]    mask_d [NUM_BARRIERS];
    logic [NUM_CORES-1:0]    arr_q  [NUM_BARRIERS];
    logic [NUM_CORES-1:0]    arr_d  [NUM_BARRIERS];

    logic [NUM_CORES-1:0]    event_q, event_d;
    logic [NUM_BARRIERS-1:0] done_q, done_d;
    logic                    err_dup_q, err_dup_d;
    logic                    err_unconf_q, err_unconf_d;

    // Per-barrier decode of the current cycle.
    logic [NUM_CORES-1:0]    new_hit  [NUM_BARRIERS];
    logic [NUM_CORES-1:0]    accepted [NUM_BARRIERS];
    logic [NUM_CORES-1:0]    nxt      [NUM_BARRIERS];
    logic [NUM_BARRIERS-1:0] cfg_hit;
    logic [NUM_BARRIERS-1:0] discard;
    logic [NUM_BARRIERS-1:0] completes;
    logic [NUM_BARRIERS-1:0] dup_hit;
    logic [NUM_BARRIERS-1:0] unconf_hit;

    always_comb begin : decode
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            for (int c = 0; c < NUM_CORES; c++) begin
                new_hit[b][c] = arrive_valid_i[c] &&
                                (arrive_id_i[c*BID_W +: BID_W] == BID_W'(b));
            end
            cfg_hit[b] = cfg_valid_i && (cfg_id_i == BID_W'(b));
            // Configuration and clear both swallow this cycle's arrivals silently.
            discard[b] = cfg_hit[b] || clear_i[b];

            if (discard[b] || (num_q[b] == '0)) begin
                accepted[b] = '0;
            end else begin
                accepted[b] = new_hit[b] & ~arr_q[b];
            end

            dup_hit[b]    = !discard[b] && (num_q[b] != '0) && |(new_hit[b] & arr_q[b]);
            unconf_hit[b] = !discard[b] && (num_q[b] == '0) && |new_hit[b];

            nxt[b]       = arr_q[b] | accepted[b];
            // Overshoot (more arrivals than team size) still completes the round.
            completes[b] = !discard[b] && (num_q[b] != '0) &&
                           (popcount(nxt[b]) >= num_q[b]);
        end
    end

    always_comb begin : next_state
        // NOTE: every _d signal gets a default before any branch so no latch is inferred.
        num_d   = num_q;
        mask_d  = mask_q;
        arr_d   = arr_q;
        event_d = '0;
        done_d  = '0;

        for (int b = 0; b < NUM_BARRIERS; b++) begin
            if (cfg_hit[b]) begin
                num_d[b]  = cfg_num_threads_i;
                mask_d[b] = cfg_mask_i;
                arr_d[b]  = '0;
            end else if (clear_i[b]) begin
                arr_d[b] = '0;
            end else if (completes[b]) begin
                arr_d[b]  = '0;
                done_d[b] = 1'b1;
                event_d   = event_d | mask_q[b];
            end else begin
                arr_d[b] = nxt[b];
            end
        end

        // A fresh error in the clearing cycle takes precedence over the clear.
        err_dup_d    = (|dup_hit)    || (err_dup_q    && !err_clr_i);
        err_unconf_d = (|unconf_hit) || (err_unconf_q && !err_clr_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the per-barrier arrays are flop-based state and are reset like any
            // other register; a reset mid-round must forget pending arrivals.
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                num_q[b]  <= '0;
                mask_q[b] <= '0;
                arr_q[b]  <= '0;
            end
            event_q      <= '0;
            done_q       <= '0;
            err_dup_q    <= 1'b0;
            err_unconf_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment only.
            num_q        <= num_d;
            mask_q       <= mask_d;
            arr_q        <= arr_d;
            event_q      <= event_d;
            done_q       <= done_d;
            err_dup_q    <= err_dup_d;
            err_unconf_q <= err_unconf_d;
        end
    end

    assign barrier_event_o = event_q;
    assign barrier_done_o  = done_q;
    assign err_dup_o       = err_dup_q;
    assign err_unconf_o    = err_unconf_q;
    assign status_count_o  = popcount(arr_q[status_id_i]);

endmodule
